arbitro_pop_ctrl: RTL and testbench

//  Pop scheduler for the two virtual-channel FIFOs (VC0, VC1) feeding the output mux stage.
//  - Issues VC0_pop/VC1_pop using weighted round-robin; VC0 is the preferred channel.
//  - Applies downstream backpressure from the D0/D1 FIFOs.
//  - Regenerates pop_delay_VC0/pop_delay_VC1 (pop delayed one cycle, aligned with FIFO read data) for the mux.

---
 rtl/arbitro_pop_ctrl.sv | 138 +++++++++++++
 tb/tb_arbitro_pop_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/arbitro_pop_ctrl.sv
// arbitro_pop_ctrl: weighted round-robin pop scheduler for the VC0/VC1 FIFOs.
// VC0 is preferred for up to VC0_WEIGHT back-to-back grants while VC1 waits.
// Either downstream almost-full flag blocks every pop. The read data lands one
// cycle after a pop, so the pop is registered into pop_delay_VCx for the mux.
// Optional feature: define ARB_STARVE_GUARD_EN to force a VC1 grant once VC1
// has waited STARVE_LIMIT eligible cycles.
module arbitro_pop_ctrl #(
    parameter int VC0_WEIGHT   = 4,
    parameter int WCNT_W       = 3,
    parameter int STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       VC0_empty,
    input  logic       VC1_empty,
    input  logic       D0_almost_full,
    input  logic       D1_almost_full,
    output logic       VC0_pop,
    output logic       VC1_pop,
    output logic       pop_delay_VC0,
    output logic       pop_delay_VC1,
    output logic [1:0] arb_state,
    output logic       starve_flag
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GNT_VC0 = 2'b01,
        GNT_VC1 = 2'b10,
        HOLD    = 2'b11
    } state_t;

    localparam logic [WCNT_W-1:0] WMAX = WCNT_W'(VC0_WEIGHT);

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              pd0_q, pd1_q;
    logic              hold;
    logic              starve;
    logic              pop0, pop1;

    // The destination of the head entry is unknown until it is read, so
    // either almost-full flag must stall both channels.
    assign hold = D0_almost_full | D1_almost_full;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCNT_W-1:0] SLIM = SCNT_W'(STARVE_LIMIT);

    logic [SCNT_W-1:0] scnt_q, scnt_d;

    // Force VC1 on the first eligible cycle after the wait budget is used up.
    assign starve = !reset && (scnt_q == SLIM) && !hold && !VC1_empty;

    // Count eligible cycles in which VC1 waits; saturate at the limit.
    always_comb begin
        scnt_d = scnt_q;
        if (pop1)
            scnt_d = '0;
        else if (!VC1_empty && !hold && (scnt_q != SLIM))
            scnt_d = scnt_q + 1'b1;
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) scnt_q <= '0;
        else       scnt_q <= scnt_d;
    end
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = |STARVE_LIMIT;
    assign starve            = 1'b0;
`endif

    // Grant decode: at most one pop, never from an empty FIFO, none under hold.
    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (!reset && !hold) begin
            if (starve)
                pop1 = 1'b1;
            else if (!VC0_empty && !VC1_empty) begin
                if (wcnt_q < WMAX) pop0 = 1'b1;
                else               pop1 = 1'b1;
            end
            else if (!VC0_empty)
                pop0 = 1'b1;
            else if (!VC1_empty)
                pop1 = 1'b1;
        end
    end

    // Weight counter: frozen under hold, reset whenever VC1 is served or has
    // nothing to send, saturating count of VC0 grants made while VC1 waits.
    always_comb begin
        wcnt_d = wcnt_q;
        if (!hold) begin
            if (pop1 || VC1_empty)
                wcnt_d = '0;
            else if (pop0 && (wcnt_q != WMAX))
                wcnt_d = wcnt_q + 1'b1;
        end
    end

    // Next-state decode; HOLD only matters if there is something to pop.
    always_comb begin
        state_d = IDLE;
        if (hold && (!VC0_empty || !VC1_empty))
            state_d = HOLD;
        else if (pop0)
            state_d = GNT_VC0;
        else if (pop1)
            state_d = GNT_VC1;
    end

    // State, weight counter and read-data-aligned pop registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            pd0_q   <= 1'b0;
            pd1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            pd0_q   <= pop0;
            pd1_q   <= pop1;
        end
    end

    assign VC0_pop       = pop0;
    assign VC1_pop       = pop1;
    assign pop_delay_VC0 = pd0_q;
    assign pop_delay_VC1 = pd1_q;
    assign arb_state     = state_q;
    assign starve_flag   = starve;

endmodule

// File: tb/tb_arbitro_pop_ctrl.sv
// Directed bench for arbitro_pop_ctrl: a cycle-by-cycle vector table plus
// hand-written reset and starvation sequences.
module tb_arbitro_pop_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       e0, e1, af0, af1;
    logic       pop0, pop1, pd0, pd1, sflag;
    logic [1:0] st;
    logic       s_pop0, s_pop1, s_pd0, s_pd1, s_flag;
    logic [1:0] s_st;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arbitro_pop_ctrl dut (
        .clk(clk), .reset(reset),
        .VC0_empty(e0), .VC1_empty(e1),
        .D0_almost_full(af0), .D1_almost_full(af1),
        .VC0_pop(pop0), .VC1_pop(pop1),
        .pop_delay_VC0(pd0), .pop_delay_VC1(pd1),
        .arb_state(st), .starve_flag(sflag)
    );

    // Second instance with a heavy VC0 weight and a short starvation limit.
    arbitro_pop_ctrl #(.VC0_WEIGHT(7), .WCNT_W(3), .STARVE_LIMIT(3)) u_s (
        .clk(clk), .reset(reset),
        .VC0_empty(e0), .VC1_empty(e1),
        .D0_almost_full(af0), .D1_almost_full(af1),
        .VC0_pop(s_pop0), .VC1_pop(s_pop1),
        .pop_delay_VC0(s_pd0), .pop_delay_VC1(s_pd1),
        .arb_state(s_st), .starve_flag(s_flag)
    );

    typedef struct {
        bit       e0, e1, af0, af1;
        bit       p0, p1, d0, d1;
        bit [1:0] st;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit ie0, ie1, ia0, ia1, xp0, xp1, xd0, xd1, input bit [1:0] xst);
        vec_t v;
        v.e0 = ie0; v.e1 = ie1; v.af0 = ia0; v.af1 = ia1;
        v.p0 = xp0; v.p1 = xp1; v.d0 = xd0; v.d1 = xd1; v.st = xst;
        tbl.push_back(v);
    endtask

    task automatic drive(input bit ie0, ie1, ia0, ia1);
        e0 = ie0; e1 = ie1; af0 = ia0; af1 = ia1;
    endtask

    // {pop0,pop1,pd0,pd1,state,starve}
    task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b (pop0,pop1,pd0,pd1,st[1:0],starve)", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1, 1, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    int first_vc1;
    bit flag_at_vc1;

    initial begin
        reset = 1'b1;
        drive(1, 1, 0, 0);
        #2;
        check("reset_state", {pop0, pop1, pd0, pd1, st, sflag}, 7'b0);
        do_reset();

        // Both nonempty: 4 VC0 grants then 1 VC1, repeating.
        add(0,0,0,0, 1,0, 0,0, 2'b00);
        add(0,0,0,0, 1,0, 1,0, 2'b01);
        add(0,0,0,0, 1,0, 1,0, 2'b01);
        add(0,0,0,0, 1,0, 1,0, 2'b01);
        add(0,0,0,0, 0,1, 1,0, 2'b01);
        add(0,0,0,0, 1,0, 0,1, 2'b10);
        add(0,0,0,0, 1,0, 1,0, 2'b01);
        add(0,0,0,0, 1,0, 1,0, 2'b01);
        add(0,0,0,0, 1,0, 1,0, 2'b01);
        add(0,0,0,0, 0,1, 1,0, 2'b01);
        add(0,0,0,0, 1,0, 0,1, 2'b10);
        add(0,0,0,0, 1,0, 1,0, 2'b01);
        // VC0 empty, VC1 nonempty: VC1 every cycle, weight counter cleared.
        add(1,0,0,0, 0,1, 1,0, 2'b01);
        add(1,0,0,0, 0,1, 0,1, 2'b10);
        add(1,0,0,0, 0,1, 0,1, 2'b10);
        add(1,0,0,0, 0,1, 0,1, 2'b10);
        add(1,0,0,0, 0,1, 0,1, 2'b10);
        // Backpressure after 2 VC0 pops; weight preserved across HOLD.
        add(0,0,0,0, 1,0, 0,1, 2'b10);
        add(0,0,0,0, 1,0, 1,0, 2'b01);
        add(0,0,0,1, 0,0, 1,0, 2'b01);
        add(0,0,0,1, 0,0, 0,0, 2'b11);
        add(0,0,0,0, 1,0, 0,0, 2'b11);
        add(0,0,0,0, 1,0, 1,0, 2'b01);
        add(0,0,0,0, 0,1, 1,0, 2'b01);
        add(0,0,1,0, 0,0, 0,1, 2'b10);
        add(0,0,0,0, 1,0, 0,0, 2'b11);
        // Last VC0 entry, then both empty -> IDLE.
        add(0,1,0,0, 1,0, 1,0, 2'b01);
        add(1,1,0,0, 0,0, 1,0, 2'b01);
        add(1,1,0,0, 0,0, 0,0, 2'b00);
        // Hold arrives together with data: hold wins.
        add(0,1,1,0, 0,0, 0,0, 2'b00);
        add(1,1,0,0, 0,0, 0,0, 2'b11);
        add(1,1,0,0, 0,0, 0,0, 2'b00);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].e0, tbl[i].e1, tbl[i].af0, tbl[i].af1);
            #1;
            check($sformatf("vec%0d", i), {pop0, pop1, pd0, pd1, st, sflag},
                  {tbl[i].p0, tbl[i].p1, tbl[i].d0, tbl[i].d1, tbl[i].st, 1'b0});
            @(posedge clk); #1;
        end

        // Reset asserted in the middle of a VC0 burst clears everything at once.
        drive(0, 0, 0, 0);
        @(posedge clk); #1;
        check("pre_reset_burst", {pop0, pop1, pd0, pd1, st, sflag}, 7'b1010010);
        #2 reset = 1'b1;
        #1 check("reset_mid_pop", {pop0, pop1, pd0, pd1, st, sflag}, 7'b0);
        drive(1, 1, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("after_release", {pop0, pop1, pd0, pd1, st, sflag}, 7'b0);

        // Starvation: weight 7, limit 3, both nonempty from a fresh reset.
        do_reset();
        first_vc1   = 0;
        flag_at_vc1 = 1'b0;
        drive(0, 0, 0, 0);
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (s_pop1 && first_vc1 == 0) begin
                first_vc1   = c;
                flag_at_vc1 = s_flag;
            end
            @(posedge clk); #1;
        end
`ifdef ARB_STARVE_GUARD_EN
        check("starve_vc1_cycle", 7'(first_vc1), 7'd4);
        check("starve_flag", {6'b0, flag_at_vc1}, 7'd1);
`else
        check("starve_vc1_cycle", 7'(first_vc1), 7'd8);
        check("starve_flag", {6'b0, flag_at_vc1}, 7'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
